nfc_cmd_scheduler: RTL and testbench
====================================

# nfc_cmd_scheduler

Command queue and issue sequencer between the AXI-Lite register block and the NAND flash controller core. Buffers register-written commands (command, address, length) in a small FIFO and issues them one at a time to the core. Before each issue it waits for the target way's ready/busy line, then tracks completion with a timeout. Exposes sticky failure/timeout flags, a drop counter and queue level for software status readback.

## Interface
Parameters:
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2.
- WAY_COUNT, 2, number of NAND ways (ready/busy lines); power of two, ≤16.
- TIMEOUT_CYCLES, 2000000, clk cycles allowed from handshake to iNfcDone; ≥2, must fit in 24 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- iCommand  in  32  command word; way index = iCommand[24 +: $clog2(WAY_COUNT)].
- iAddress  in  32  target address.
- iLength  in  16  transfer length.
- iCommandValid  in  1  one-cycle enqueue strobe.
- iClearStatus  in  1  one-cycle strobe; clears sticky flags and drop count.
- iNandRB  in  WAY_COUNT  per-way ready/busy; 1 = ready.
- oNfcCommand  out  32  issued command.
- oNfcAddress  out  32  issued address.
- oNfcLength  out  16  issued length.
- oNfcValid  out  1  issue request.
- iNfcReady  in  1  core accepts the request.
- iNfcDone  in  1  one-cycle completion pulse.
- iNfcFail  in  1  failure qualifier; sampled with iNfcDone.
- oQueueLevel  out  $clog2(QUEUE_DEPTH)+1  current FIFO occupancy.
- oQueueFull  out  1  level == QUEUE_DEPTH.
- oBusy  out  1  state != IDLE, or level != 0.
- oCommandFail  out  1  sticky; set by iNfcFail or a timeout.
- oTimeout  out  1  sticky; set by a timeout.
- oDropCount  out  8  saturating count of commands dropped because the FIFO was full.

## Operation
- Enqueue: iCommandValid pushes {iCommand, iAddress, iLength} when pre-edge level < QUEUE_DEPTH. If the FIFO is full, the command is dropped and oDropCount increments, saturating at 255. This holds even if a pop occurs in the same cycle.
- The FIFO supports a simultaneous push and pop. The level is then unchanged and entry order is preserved.
- State machine:
  - IDLE: if level != 0, pop the head into the issue registers → WAIT_RB.
  - WAIT_RB: if iNandRB[way] == 1 → ISSUE.
  - ISSUE: oNfcValid = 1, issue registers stable. On iNfcValid&&iNfcReady (oNfcValid && iNfcReady) → WAIT_DONE, clear the timeout counter.
  - WAIT_DONE: on iNfcDone → IDLE; set oCommandFail if iNfcFail. If the counter reaches TIMEOUT_CYCLES-1 without iNfcDone → IDLE; set oTimeout and oCommandFail. If iNfcDone and the timeout coincide, iNfcDone wins and the timeout flag is not set.
- iNfcDone outside WAIT_DONE is ignored.
- iClearStatus clears oCommandFail, oTimeout and oDropCount. If a set event occurs in the same cycle, the set wins. A drop in the same cycle leaves the count at 1.
- A command is never reissued after a failure or timeout; the queue keeps draining.
- If the way index is ≥ WAY_COUNT, the index uses the low bits only (natural truncation).

## Timing
- Reset: state IDLE, FIFO empty, oQueueLevel 0, oQueueFull 0, oBusy 0, oNfcValid 0, oNfcCommand/oNfcAddress/oNfcLength 0, oCommandFail 0, oTimeout 0, oDropCount 0, timeout counter 0.
- rst mid-operation discards the queue and any in-flight tracking. The core is not notified.
- Latency, for an empty FIFO, IDLE state and way ready: iCommandValid at edge N gives oQueueLevel=1 after N. The pop happens at N+1 and oNfcValid is high after N+2.
- oNfcValid is registered and drops the edge after the handshake.
- The payload is unchanged while oNfcValid is high.
- The FIFO level updates one edge after a push/pop.
- All outputs are registered except oQueueFull and oBusy, which are decoded from registers.
- The timeout counter is 24-bit, incrementing once per cycle in WAIT_DONE.

## Structure
- Package nfc_sched_pkg: state enum (IDLE, WAIT_RB, ISSUE, WAIT_DONE), entry width constant (80), way-field offset (24), drop-counter width (8).
- Sub-module nfc_cmd_fifo: synchronous FIFO, parameterised width/depth, with push, pop, level and full/empty outputs. Register-based storage.
- The top level holds the FSM, issue registers, timeout counter and status flags.

## Test plan
- Single command 0x00000011 / address 0x1000 / length 2048, way 0 ready, iNfcReady=1 → oNfcValid high 2 edges after the enqueue edge with exact payload; iNfcDone with iNfcFail=0 → IDLE, oBusy 0, flags 0.
- Four back-to-back enqueues plus a fifth while full → oQueueFull 1, oDropCount 1. Issue order matches enqueue order. The fifth command is never issued.
- Way 1 command with iNandRB=2'b01 for 50 cycles → oNfcValid stays 0. Raise iNandRB[1] → ISSUE on the following edge.
- TIMEOUT_CYCLES=16, no iNfcDone → oTimeout and oCommandFail set after 16 WAIT_DONE cycles. The next queued command issues. iClearStatus clears both.
- iNfcDone with iNfcFail=1 coincident with iClearStatus → oCommandFail stays 1. iNfcDone coincident with the timeout cycle → oTimeout stays 0.
- rst asserted in WAIT_DONE with 2 entries queued → all outputs reach reset values the next edge. No issue follows.

Source files
------------

// File: rtl/nfc_sched_pkg.sv
// rtl/nfc_sched_pkg.sv - shared types and constants for the NAND command scheduler
package nfc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RB   = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_e;

  localparam int ENTRY_W       = 80;
  localparam int WAY_FIELD_LSB = 24;
  localparam int DROP_CNT_W    = 8;
  localparam int TIMER_W       = 24;

  typedef struct packed {
    logic [31:0] command;
    logic [31:0] address;
    logic [15:0] length;
  } cmd_entry_t;

endpackage

// File: rtl/nfc_cmd_fifo.sv
// rtl/nfc_cmd_fifo.sv - register-based synchronous FIFO with simultaneous push/pop
module nfc_cmd_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointers, level and storage; a push and pop together keep the level and order.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Pointer and level registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nfc_cmd_scheduler.sv
// rtl/nfc_cmd_scheduler.sv - queues register-written commands and issues them to the NAND core
module nfc_cmd_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int WAY_COUNT      = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  iCommand,
  input  logic [31:0]                  iAddress,
  input  logic [15:0]                  iLength,
  input  logic                         iCommandValid,
  input  logic                         iClearStatus,
  input  logic [WAY_COUNT-1:0]         iNandRB,
  output logic [31:0]                  oNfcCommand,
  output logic [31:0]                  oNfcAddress,
  output logic [15:0]                  oNfcLength,
  output logic                         oNfcValid,
  input  logic                         iNfcReady,
  input  logic                         iNfcDone,
  input  logic                         iNfcFail,
  output logic [$clog2(QUEUE_DEPTH):0] oQueueLevel,
  output logic                         oQueueFull,
  output logic                         oBusy,
  output logic                         oCommandFail,
  output logic                         oTimeout,
  output logic [7:0]                   oDropCount
);

  import nfc_sched_pkg::*;

  localparam int WAY_W = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  sched_state_e            state_q, state_d;
  logic [31:0]             cmd_q, cmd_d;
  logic [31:0]             addr_q, addr_d;
  logic [15:0]             len_q, len_d;
  logic                    valid_q, valid_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    fail_q, fail_d;
  logic                    timeout_q, timeout_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;

  cmd_entry_t              push_entry;
  cmd_entry_t              head_entry;
  logic [ENTRY_W-1:0]      head_raw;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    fail_set;
  logic                    timeout_set;
  logic                    drop_evt;
  logic [WAY_W-1:0]        way_idx;

  assign push_entry = '{command: iCommand, address: iAddress, length: iLength};
  assign head_entry = cmd_entry_t'(head_raw);
  // A full FIFO drops the command even when a pop frees a slot on the same edge.
  assign drop_evt   = iCommandValid && fifo_full;
  assign way_idx    = cmd_q[WAY_FIELD_LSB +: WAY_W];

  nfc_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (iCommandValid),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_raw),
    .level (oQueueLevel),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue sequencer: pop, wait for the way to be ready, handshake, then track completion.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    valid_d     = valid_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    fail_set    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = head_entry.command;
          addr_d  = head_entry.address;
          len_d   = head_entry.length;
          state_d = WAIT_RB;
        end
      end
      WAIT_RB: begin
        if (iNandRB[way_idx]) begin
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (valid_q && iNfcReady) begin
          valid_d = 1'b0;
          timer_d = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (iNfcDone) begin
          fail_set = iNfcFail;
          state_d  = IDLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          fail_set    = 1'b1;
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky status: clear first, then any set event in the same cycle wins.
  always_comb begin
    fail_d    = fail_q;
    timeout_d = timeout_q;
    drop_d    = drop_q;
    if (iClearStatus) begin
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      drop_d    = '0;
    end
    if (fail_set) begin
      fail_d = 1'b1;
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end
    if (drop_evt && (drop_d != '1)) begin
      drop_d = drop_d + DROP_CNT_W'(1);
    end
  end

  // State, issue and status registers; reset drops any in-flight command silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      timer_q   <= '0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      drop_q    <= drop_d;
    end
  end

  assign oNfcCommand  = cmd_q;
  assign oNfcAddress  = addr_q;
  assign oNfcLength   = len_q;
  assign oNfcValid    = valid_q;
  assign oQueueFull   = fifo_full;
  assign oBusy        = (state_q != IDLE) || !fifo_empty;
  assign oCommandFail = fail_q;
  assign oTimeout     = timeout_q;
  assign oDropCount   = drop_q;

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// tb/tb_nfc_cmd_scheduler.sv - randomized and directed bench for nfc_cmd_scheduler
module tb_nfc_cmd_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iCommand = '0;
  logic [31:0] iAddress = '0;
  logic [15:0] iLength = '0;
  logic        iCommandValid = 1'b0;
  logic        iClearStatus = 1'b0;
  logic [1:0]  iNandRB = '0;
  logic        iNfcReady = 1'b0;
  logic        iNfcDone = 1'b0;
  logic        iNfcFail = 1'b0;
  logic [31:0] oNfcCommand;
  logic [31:0] oNfcAddress;
  logic [15:0] oNfcLength;
  logic        oNfcValid;
  logic [2:0]  oQueueLevel;
  logic        oQueueFull;
  logic        oBusy;
  logic        oCommandFail;
  logic        oTimeout;
  logic [7:0]  oDropCount;

  nfc_cmd_scheduler #(
    .QUEUE_DEPTH    (DEPTH),
    .WAY_COUNT      (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .iCommand      (iCommand),
    .iAddress      (iAddress),
    .iLength       (iLength),
    .iCommandValid (iCommandValid),
    .iClearStatus  (iClearStatus),
    .iNandRB       (iNandRB),
    .oNfcCommand   (oNfcCommand),
    .oNfcAddress   (oNfcAddress),
    .oNfcLength    (oNfcLength),
    .oNfcValid     (oNfcValid),
    .iNfcReady     (iNfcReady),
    .iNfcDone      (iNfcDone),
    .iNfcFail      (iNfcFail),
    .oQueueLevel   (oQueueLevel),
    .oQueueFull    (oQueueFull),
    .oBusy         (oBusy),
    .oCommandFail  (oCommandFail),
    .oTimeout      (oTimeout),
    .oDropCount    (oDropCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: command queue plus the one command the scheduler owns.
  logic [79:0] mq[$];
  logic [79:0] m_head = '0;
  bit          m_busy = 0;
  bit          m_phase = 0;
  bit          m_rb_seen = 0;
  int          m_cnt = 0;
  bit          m_fail = 0;
  bit          m_tmo = 0;
  int          m_drop = 0;

  int          dut_issued = 0;
  logic [79:0] dut_log[$];

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    logic hs;
    bit   pop_e, push_e, drop_e, sf, st;
    int   occ;
    hs = oNfcValid && iNfcReady;
    if (hs === 1'b1 && !rst) begin
      dut_issued++;
      dut_log.push_back({oNfcCommand, oNfcAddress, oNfcLength});
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_busy = 0; m_phase = 0; m_rb_seen = 0; m_cnt = 0;
      m_fail = 0; m_tmo = 0; m_drop = 0;
    end else begin
      occ    = mq.size();
      pop_e  = !m_busy && occ > 0;
      push_e = iCommandValid && occ < DEPTH;
      drop_e = iCommandValid && !push_e;
      sf = 0; st = 0;
      if (m_busy) begin
        if (!m_phase) begin
          if (!m_rb_seen) begin
            if (iNandRB[m_head[72]]) m_rb_seen = 1;
          end else if (iNfcReady) begin
            m_phase = 1;
            m_cnt   = 0;
          end
        end else begin
          if (iNfcDone) begin
            m_busy = 0;
            sf     = iNfcFail;
          end else if (m_cnt == TIMEOUT - 1) begin
            m_busy = 0;
            sf     = 1;
            st     = 1;
          end else begin
            m_cnt++;
          end
        end
      end
      if (pop_e) begin
        m_head    = mq.pop_front();
        m_busy    = 1;
        m_phase   = 0;
        m_rb_seen = 0;
      end
      if (push_e) mq.push_back({iCommand, iAddress, iLength});
      if (iClearStatus) begin
        m_fail = 0; m_tmo = 0; m_drop = 0;
      end
      if (sf) m_fail = 1;
      if (st) m_tmo = 1;
      if (drop_e) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
    end
    #1;
    chk("level", 80'(oQueueLevel), 80'(mq.size()));
    chk("full", 80'(oQueueFull), 80'(mq.size() == DEPTH));
    chk("busy", 80'(oBusy), 80'(m_busy || mq.size() != 0));
    chk("valid", 80'(oNfcValid), 80'(m_busy && !m_phase && m_rb_seen));
    chk("cmd_fail", 80'(oCommandFail), 80'(m_fail));
    chk("timeout", 80'(oTimeout), 80'(m_tmo));
    chk("drop", 80'(oDropCount), 80'(m_drop));
    if (m_busy && !m_phase && m_rb_seen)
      chk("payload", {oNfcCommand, oNfcAddress, oNfcLength}, m_head);
  endtask

  task automatic enq(input logic [31:0] c, input logic [31:0] a, input logic [15:0] l);
    iCommand      = c;
    iAddress      = a;
    iLength       = l;
    iCommandValid = 1'b1;
    step();
    iCommandValid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    iCommandValid = 1'b0;
    iClearStatus  = 1'b0;
    iNandRB       = 2'b11;
    iNfcReady     = 1'b1;
    while ((m_busy || mq.size() != 0) && n < max_cyc) begin
      iNfcDone = m_busy && m_phase;
      iNfcFail = 1'b0;
      step();
      n++;
    end
    iNfcDone = 1'b0;
    chk("drain_idle", 80'(oBusy), 80'(1'b0));
  endtask

  task automatic wait_done_phase(input int max_cyc);
    int n = 0;
    while (!(m_busy && m_phase) && n < max_cyc) begin
      step();
      n++;
    end
    chk("reach_wait_done", 80'(n < max_cyc), 80'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          base;
    logic [79:0] last_pl;

    // Reset values
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_payload", {oNfcCommand, oNfcAddress, oNfcLength}, 80'(0));
    chk("rst_valid", 80'(oNfcValid), 80'(1'b0));
    chk("rst_level", 80'(oQueueLevel), 80'(0));
    chk("rst_busy", 80'(oBusy), 80'(1'b0));

    // Single command, latency and exact payload
    iNandRB   = 2'b11;
    iNfcReady = 1'b1;
    enq(32'h0000_0011, 32'h0000_1000, 16'd2048);
    chk("t1_level", 80'(oQueueLevel), 80'(1));
    step();
    chk("t1_valid_n1", 80'(oNfcValid), 80'(1'b0));
    step();
    chk("t1_valid_n2", 80'(oNfcValid), 80'(1'b1));
    chk("t1_payload", {oNfcCommand, oNfcAddress, oNfcLength},
        {32'h0000_0011, 32'h0000_1000, 16'd2048});
    step();
    chk("t1_valid_drop", 80'(oNfcValid), 80'(1'b0));
    iNfcDone = 1'b1;
    iNfcFail = 1'b0;
    step();
    iNfcDone = 1'b0;
    chk("t1_busy", 80'(oBusy), 80'(1'b0));
    chk("t1_fail", 80'(oCommandFail), 80'(1'b0));

    // Full queue and drop; order preserved, dropped command never issued
    iNandRB = 2'b00;
    enq(32'h0000_0100, 32'h0, 16'd1);
    step();
    step();
    base = dut_issued;
    for (int i = 0; i < 5; i++) begin
      enq(32'h0000_0200 + 32'(i), 32'h10 * 32'(i), 16'(i));
      if (i == 3) last_pl = {32'h0000_0203, 32'h30, 16'd3};
    end
    chk("t2_full", 80'(oQueueFull), 80'(1'b1));
    chk("t2_drop", 80'(oDropCount), 80'(1));
    drain(200);
    chk("t2_issued", 80'(dut_issued - base), 80'(5));
    chk("t2_last", dut_log[dut_log.size() - 1], last_pl);

    // Way 1 held busy
    iNandRB = 2'b01;
    enq(32'h0100_0022, 32'h2000, 16'd64);
    for (int i = 0; i < 50; i++) step();
    chk("t3_held", 80'(oNfcValid), 80'(1'b0));
    iNandRB = 2'b11;
    step();
    chk("t3_issue", 80'(oNfcValid), 80'(1'b1));
    drain(50);

    // Timeout, next command still issues, clear
    base = dut_issued;
    iNfcDone = 1'b0;
    enq(32'h0000_0033, 32'h3000, 16'd8);
    enq(32'h0000_0034, 32'h3100, 16'd9);
    step();
    step();
    chk("t4_hs", 80'(dut_issued - base), 80'(1));
    for (int i = 0; i < 15; i++) step();
    chk("t4_tmo_early", 80'(oTimeout), 80'(1'b0));
    step();
    chk("t4_tmo", 80'(oTimeout), 80'(1'b1));
    chk("t4_fail", 80'(oCommandFail), 80'(1'b1));
    drain(50);
    chk("t4_second", 80'(dut_issued - base), 80'(2));
    iClearStatus = 1'b1;
    step();
    iClearStatus = 1'b0;
    chk("t4_clr_tmo", 80'(oTimeout), 80'(1'b0));
    chk("t4_clr_fail", 80'(oCommandFail), 80'(1'b0));

    // Done on the timeout cycle wins
    enq(32'h0000_0044, 32'h4000, 16'd4);
    wait_done_phase(20);
    for (int i = 0; i < 15; i++) step();
    iNfcDone = 1'b1;
    iNfcFail = 1'b0;
    step();
    iNfcDone = 1'b0;
    chk("t5_tmo_race", 80'(oTimeout), 80'(1'b0));
    chk("t5_fail_race", 80'(oCommandFail), 80'(1'b0));

    // Fail set coincident with clear
    enq(32'h0000_0055, 32'h5000, 16'd5);
    wait_done_phase(20);
    iNfcDone     = 1'b1;
    iNfcFail     = 1'b1;
    iClearStatus = 1'b1;
    step();
    iNfcDone     = 1'b0;
    iNfcFail     = 1'b0;
    iClearStatus = 1'b0;
    chk("t5_set_wins", 80'(oCommandFail), 80'(1'b1));

    // Reset in WAIT_DONE with two queued
    enq(32'h0000_0066, 32'h6000, 16'd6);
    enq(32'h0000_0067, 32'h6100, 16'd7);
    enq(32'h0000_0068, 32'h6200, 16'd8);
    wait_done_phase(20);
    chk("t6_level", 80'(oQueueLevel), 80'(2));
    base = dut_issued;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_level0", 80'(oQueueLevel), 80'(0));
    chk("t6_busy0", 80'(oBusy), 80'(1'b0));
    chk("t6_fail0", 80'(oCommandFail), 80'(1'b0));
    chk("t6_payload0", {oNfcCommand, oNfcAddress, oNfcLength}, 80'(0));
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_issue", 80'(dut_issued - base), 80'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      iCommandValid = ($urandom_range(0, 2) == 0);
      iCommand      = $urandom();
      iAddress      = $urandom();
      iLength       = 16'($urandom());
      iNandRB       = 2'($urandom());
      iNfcReady     = 1'($urandom());
      iNfcDone      = ($urandom_range(0, 7) == 0);
      iNfcFail      = 1'($urandom());
      iClearStatus  = ($urandom_range(0, 29) == 0);
      step();
    end
    iNfcDone = 1'b0;
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
